// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: single-beat AXI4 read address and read data channels
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [2:0]        arport;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arport, arvalid, rready,
    input  arready, rid, rdata, rresp, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arport, arvalid, rready,
    output arready, rid, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin share of one AXI read port between fetch and load/store, one beat in flight
module axi_rd_arbiter #(
  parameter int              ADDR_W = 64,
  parameter int              DATA_W = 64,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] IF_ID  = 4'd0,
  parameter logic [ID_W-1:0] LS_ID  = 4'd1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [2:0]        ls_size,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  axi_rd_arbiter_if.master  axi
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state;
  logic last_ls, owner_ls, sel_ls;
  // LS wins only when alone or when IF took the previous grant
  assign sel_ls       = ls_req_valid & (~if_req_valid | ~last_ls);
  assign if_req_ready = rstn & (state == IDLE) & if_req_valid & ~sel_ls;
  assign ls_req_ready = rstn & (state == IDLE) & sel_ls;
  assign axi.arlen    = '0;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      last_ls      <= 1'b1;
      owner_ls     <= 1'b0;
      axi.arid     <= '0;
      axi.araddr   <= '0;
      axi.arsize   <= '0;
      axi.arburst  <= '0;
      axi.arport   <= '0;
      axi.arvalid  <= 1'b0;
      axi.rready   <= 1'b0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_data  <= '0;
      ls_rsp_err   <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if (state == IDLE && (if_req_valid || ls_req_valid)) begin
        owner_ls    <= sel_ls;
        last_ls     <= sel_ls;
        axi.arid    <= sel_ls ? LS_ID : IF_ID;
        axi.araddr  <= sel_ls ? ls_addr : if_addr;
        axi.arsize  <= sel_ls ? ls_size : 3'b010;
        axi.arport  <= sel_ls ? 3'b000 : 3'b100;
        axi.arburst <= 2'b01;
        axi.arvalid <= 1'b1;
        state       <= ADDR;
      end else if (state == ADDR && axi.arready) begin
        axi.arvalid <= 1'b0;
        axi.rready  <= 1'b1;
        state       <= DATA;
      end else if (state == DATA && axi.rvalid && axi.rid == axi.arid) begin
        axi.rready <= 1'b0;
        state      <= IDLE;
        if (owner_ls) begin
          ls_rsp_valid <= 1'b1;
          ls_rsp_data  <= axi.rdata;
          ls_rsp_err   <= axi.rresp != 2'b00;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= axi.rdata;
          if_rsp_err   <= axi.rresp != 2'b00;
        end
      end
    end
  end
endmodule
